// File: rtl/alu_op_sequencer_if.sv
// Bundle between the sequencer, its command/response clients and the ALU.
// slave = sequencer view; master = surrounding control logic plus ALU.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3,
    parameter int CNTW  = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [OPW-1:0]   cmd_opcode;
    logic             cmd_chain;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_opcode;
    logic [WIDTH-1:0] alu_acc;
    logic             alu_carry;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;

    logic             busy;
    logic [CNTW-1:0]  op_count;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_chain,
        input  alu_acc, alu_carry, alu_zero,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_opcode,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero,
        output busy, op_count
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_chain,
        output alu_acc, alu_carry, alu_zero,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_opcode,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero,
        input  busy, op_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation at a time, holds the ALU inputs while it settles,
// then captures accumulator/carry/zero into a registered response.
module alu_op_sequencer #(
    parameter int WIDTH   = 16,
    parameter int OPW     = 3,
    parameter int LATENCY = 1,
    parameter int CNTW    = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    alu_op_sequencer_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(LATENCY);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] alu_a_q,   alu_a_d;
    logic [WIDTH-1:0] alu_b_q,   alu_b_d;
    logic [OPW-1:0]   alu_op_q,  alu_op_d;
    logic [3:0]       wait_q,    wait_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             carry_q,   carry_d;
    logic             zero_q,    zero_d;
    logic [WIDTH-1:0] chain_q,   chain_d;
    logic [CNTW-1:0]  count_q,   count_d;

    always_comb begin
        state_d  = state_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        wait_d   = wait_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        chain_d  = chain_q;
        count_d  = count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    alu_a_d  = bus.cmd_chain ? chain_q : bus.cmd_a;
                    alu_b_d  = bus.cmd_b;
                    alu_op_d = bus.cmd_opcode;
                    wait_d   = WAIT_INIT;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // ALU inputs stay frozen here: its arithmetic path clears
                // if the opcode wanders out of the arithmetic range.
                if (wait_q == 4'd0) begin
                    result_d = bus.alu_acc;
                    carry_d  = bus.alu_carry;
                    zero_d   = bus.alu_zero;
                    chain_d  = bus.alu_acc;
                    state_d  = ST_RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    count_d = count_q + CNTW'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            wait_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            chain_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            wait_q   <= wait_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            chain_q  <= chain_d;
            count_q  <= count_d;
        end
    end

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.op_count   = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a LATENCY=1 instance behind a registered ALU
// model and a LATENCY=0 instance behind a combinational ALU model.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_op  = 0;

    logic        sel0 = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [2:0]  cmd_op = '0;
    logic        cmd_chain = 1'b0;
    logic        rsp_ready = 1'b0;

    logic [15:0] chain_m [2];
    int          cnt_m   [2];

    // Reference ALU: returns {carry, zero, result}
    function automatic logic [17:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op);
        logic [16:0] s;
        case (op)
            3'd0:    s = {1'b0, a & b};
            3'd1:    s = {1'b0, a | b};
            3'd2:    s = {1'b0, a ^ b};
            3'd3:    s = {1'b0, ~(a & b)};
            3'd4:    s = {1'b0, ~(a | b)};
            3'd5:    s = {1'b0, a} + {1'b0, b};
            3'd6:    s = {1'b0, a} - {1'b0, b};
            default: s = {1'b0, a} + 17'd1;
        endcase
        return {s[16], (s[15:0] == 16'd0), s[15:0]};
    endfunction

    alu_op_sequencer_if #(.WIDTH(16), .OPW(3), .CNTW(8)) if0 ();
    alu_op_sequencer_if #(.WIDTH(16), .OPW(3), .CNTW(8)) if1 ();

    alu_op_sequencer #(.WIDTH(16), .OPW(3), .LATENCY(0), .CNTW(8)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if0));
    alu_op_sequencer #(.WIDTH(16), .OPW(3), .LATENCY(1), .CNTW(8)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1));

    assign if0.cmd_valid  = cmd_valid & sel0;
    assign if1.cmd_valid  = cmd_valid & ~sel0;
    assign if0.rsp_ready  = rsp_ready & sel0;
    assign if1.rsp_ready  = rsp_ready & ~sel0;
    assign if0.cmd_a = cmd_a;       assign if1.cmd_a = cmd_a;
    assign if0.cmd_b = cmd_b;       assign if1.cmd_b = cmd_b;
    assign if0.cmd_opcode = cmd_op; assign if1.cmd_opcode = cmd_op;
    assign if0.cmd_chain = cmd_chain; assign if1.cmd_chain = cmd_chain;

    assign {if0.alu_carry, if0.alu_zero, if0.alu_acc} =
        alu_fn(if0.alu_a, if0.alu_b, if0.alu_opcode);

    logic [17:0] alu1_q = '0;
    always @(posedge clk) alu1_q <= alu_fn(if1.alu_a, if1.alu_b, if1.alu_opcode);
    assign {if1.alu_carry, if1.alu_zero, if1.alu_acc} = alu1_q;

    wire        o_cmd_ready = sel0 ? if0.cmd_ready  : if1.cmd_ready;
    wire        o_rsp_valid = sel0 ? if0.rsp_valid  : if1.rsp_valid;
    wire [15:0] o_alu_a     = sel0 ? if0.alu_a      : if1.alu_a;
    wire [15:0] o_alu_b     = sel0 ? if0.alu_b      : if1.alu_b;
    wire [2:0]  o_alu_op    = sel0 ? if0.alu_opcode : if1.alu_opcode;
    wire [15:0] o_result    = sel0 ? if0.rsp_result : if1.rsp_result;
    wire        o_carry     = sel0 ? if0.rsp_carry  : if1.rsp_carry;
    wire        o_zero      = sel0 ? if0.rsp_zero   : if1.rsp_zero;
    wire        o_busy      = sel0 ? if0.busy       : if1.busy;
    wire [7:0]  o_count     = sel0 ? if0.op_count   : if1.op_count;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic scramble_cmd();
        cmd_a     = 16'($urandom);
        cmd_b     = 16'($urandom);
        cmd_op    = 3'($urandom);
        cmd_chain = 1'($urandom);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         input logic ch, input int stall);
        logic [15:0] a_eff;
        logic [17:0] r;
        int d;
        int lat;
        int k;
        d     = sel0 ? 0 : 1;
        lat   = sel0 ? 0 : 1;
        a_eff = ch ? chain_m[d] : a;
        r     = alu_fn(a_eff, b, op);

        @(negedge clk);
        chk_eq("ready_before", 32'(o_cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = ch;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        chk_eq("alu_a", 32'(o_alu_a), 32'(a_eff));
        chk_eq("alu_b", 32'(o_alu_b), 32'(b));
        chk_eq("alu_op", 32'(o_alu_op), 32'(op));
        chk_eq("busy_e0", 32'(o_busy), 32'd1);
        chk_eq("ready_e0", 32'(o_cmd_ready), 32'd0);
        chk_eq("valid_e0", 32'(o_rsp_valid), 32'd0);
        scramble_cmd();

        k = 0;
        while (!o_rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
            scramble_cmd();
        end
        chk_eq("latency", 32'(k), 32'(lat + 1));
        chk_eq("result", 32'(o_result), 32'(r[15:0]));
        chk_eq("carry", 32'(o_carry), 32'(r[17]));
        chk_eq("zero", 32'(o_zero), 32'(r[16]));

        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk_eq("bp_result", 32'(o_result), 32'(r[15:0]));
            chk_eq("bp_valid", 32'(o_rsp_valid), 32'd1);
            chk_eq("bp_ready", 32'(o_cmd_ready), 32'd0);
            chk_eq("bp_alu_a", 32'(o_alu_a), 32'(a_eff));
            chk_eq("bp_alu_b", 32'(o_alu_b), 32'(b));
            scramble_cmd();
        end

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chain_m[d] = r[15:0];
        cnt_m[d]++;
        chk_eq("hs_valid", 32'(o_rsp_valid), 32'd0);
        chk_eq("hs_ready", 32'(o_cmd_ready), 32'd1);
        chk_eq("hs_busy", 32'(o_busy), 32'd0);
        chk_eq("op_count", 32'(o_count), 32'(cnt_m[d] % 256));
        chk_eq("hs_alu_a", 32'(o_alu_a), 32'(a_eff));
        cmd_valid = 1'b0;

        n_op++;
        $display("op%0d lat=%0d a=%h b=%h op=%0d chain=%0b -> res=%h c=%0b z=%0b cnt=%0d",
                 n_op, lat, a_eff, b, op, ch, o_result, o_carry, o_zero, o_count);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_eq("rst_alu_a", 32'(o_alu_a), 32'd0);
        chk_eq("rst_alu_b", 32'(o_alu_b), 32'd0);
        chk_eq("rst_alu_op", 32'(o_alu_op), 32'd0);
        chk_eq("rst_result", 32'(o_result), 32'd0);
        chk_eq("rst_valid", 32'(o_rsp_valid), 32'd0);
        chk_eq("rst_busy", 32'(o_busy), 32'd0);
        chk_eq("rst_count", 32'(o_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chain_m[0] = '0; chain_m[1] = '0;
        cnt_m[0] = 0;    cnt_m[1] = 0;
    endtask

    initial begin
        chain_m[0] = '0; chain_m[1] = '0;
        cnt_m[0] = 0;    cnt_m[1] = 0;
        repeat (3) @(posedge clk);
        apply_reset();
        @(negedge clk);
        chk_eq("post_rst_ready", 32'(o_cmd_ready), 32'd1);

        // Directed cases on the LATENCY=1 instance
        do_op(16'h0005, 16'h0003, 3'd5, 1'b0, 0);
        do_op(16'h1234, 16'h0001, 3'd5, 1'b1, 0);
        do_op(16'hFFFF, 16'h0001, 3'd5, 1'b0, 0);
        do_op(16'hF0F0, 16'h0F0F, 3'd0, 1'b0, 0);
        do_op(16'hABCD, 16'h1111, 3'd6, 1'b0, 5);

        for (int i = 0; i < 20; i++)
            do_op(16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)));

        // Reset one edge into HOLD: operation must vanish without a response
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 16'h0042; cmd_b = 16'h0001; cmd_op = 3'd5; cmd_chain = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_eq("abort_alu_a", 32'(o_alu_a), 32'd0);
        chk_eq("abort_valid", 32'(o_rsp_valid), 32'd0);
        chk_eq("abort_busy", 32'(o_busy), 32'd0);
        chk_eq("abort_count", 32'(o_count), 32'd0);
        chk_eq("abort_result", 32'(o_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chain_m[0] = '0; chain_m[1] = '0;
        cnt_m[0] = 0;    cnt_m[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("abort_no_rsp", 32'(o_rsp_valid), 32'd0);
        do_op(16'h1234, 16'h0001, 3'd5, 1'b1, 0);

        // Counter wrap
        apply_reset();
        for (int i = 0; i < 256; i++)
            do_op(16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom), 0);
        chk_eq("wrap", 32'(o_count), 32'd0);

        // LATENCY=0 instance
        sel0 = 1'b1;
        do_op(16'h0005, 16'h0003, 3'd5, 1'b0, 0);
        do_op(16'h1234, 16'h0001, 3'd5, 1'b1, 2);
        do_op(16'hFFFF, 16'h0001, 3'd5, 1'b0, 0);
        for (int i = 0; i < 10; i++)
            do_op(16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=0x0 exp=0x1");
        $fatal(1, "timeout");
    end

endmodule
